// File: rtl/ip_tx.sv
// IPv4 transmit framer: selects an ICMP or UDP payload stream, prepends a
// 20-byte IPv4 header with computed checksum and emits the packet toward the MAC.
module ip_tx #(
    parameter logic [31:0] P_ST_TARGET_IP = {8'd192, 8'd168, 8'd1, 8'd0},
    parameter logic [31:0] P_ST_SOURCE_IP = {8'd192, 8'd168, 8'd1, 8'd1},
    parameter logic [7:0]  P_TTL          = 8'd64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_target_ip,
    input  logic        i_target_valid,
    input  logic [31:0] i_source_ip,
    input  logic        i_source_valid,
    input  logic [7:0]  i_udp_data,
    input  logic [15:0] i_udp_len,
    input  logic        i_udp_last,
    input  logic        i_udp_valid,
    output logic        o_udp_ready,
    input  logic [7:0]  i_icmp_data,
    input  logic [15:0] i_icmp_len,
    input  logic        i_icmp_last,
    input  logic        i_icmp_valid,
    output logic        o_icmp_ready,
    output logic [7:0]  o_mac_data,
    output logic        o_mac_last,
    output logic        o_mac_valid,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CSUM0   = 3'd1,
        CSUM1   = 3'd2,
        HEADER  = 3'd3,
        PAYLOAD = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] target_ip_q, source_ip_q;
    logic [15:0] id_q;
    logic        sel_icmp_q;
    logic [15:0] len_q, pkt_id_q, pay_cnt_q, csum_q;
    logic [7:0]  proto_q;
    logic [31:0] src_q, dst_q, sum_q;
    logic [4:0]  hdr_cnt_q;

    logic [15:0] tot_len;
    logic [31:0] sum_words;
    logic [16:0] fold1;
    logic [15:0] fold2;
    logic [7:0]  hdr_byte;
    logic        in_ready, in_valid, accept, last_acc, any_req;
    logic [7:0]  in_data;
    logic        unused_last;

    // i_*_last is deliberately ignored: the captured length decides where the packet ends.
    assign unused_last = i_udp_last ^ i_icmp_last;

    assign o_dbg_state = state_q;
    assign any_req     = i_icmp_valid | i_udp_valid;
    assign tot_len     = len_q + 16'd20;

    assign sum_words = 32'h0000_4500 + {16'b0, tot_len} + {16'b0, pkt_id_q}
                     + 32'h0000_4000 + {16'b0, P_TTL, proto_q}
                     + {16'b0, src_q[31:16]} + {16'b0, src_q[15:0]}
                     + {16'b0, dst_q[31:16]} + {16'b0, dst_q[15:0]};
    assign fold1 = {1'b0, sum_q[15:0]} + {1'b0, sum_q[31:16]};
    assign fold2 = fold1[15:0] + {15'b0, fold1[16]};

    // Handshake: a payload byte moves on a cycle where the selected valid and ready
    // are both 1; ready depends only on state/count, never on valid.
    assign in_ready     = (state_q == PAYLOAD) && (pay_cnt_q != len_q);
    assign o_icmp_ready = in_ready && sel_icmp_q;
    assign o_udp_ready  = in_ready && !sel_icmp_q;
    assign in_valid     = sel_icmp_q ? i_icmp_valid : i_udp_valid;
    assign in_data      = sel_icmp_q ? i_icmp_data : i_udp_data;
    assign accept       = in_ready && in_valid;
    assign last_acc     = accept && (pay_cnt_q == len_q - 16'd1);

    always_comb begin
        hdr_byte = 8'h00;
        case (hdr_cnt_q)
            5'd0:    hdr_byte = 8'h45;
            5'd1:    hdr_byte = 8'h00;
            5'd2:    hdr_byte = tot_len[15:8];
            5'd3:    hdr_byte = tot_len[7:0];
            5'd4:    hdr_byte = pkt_id_q[15:8];
            5'd5:    hdr_byte = pkt_id_q[7:0];
            5'd6:    hdr_byte = 8'h40;
            5'd7:    hdr_byte = 8'h00;
            5'd8:    hdr_byte = P_TTL;
            5'd9:    hdr_byte = proto_q;
            5'd10:   hdr_byte = csum_q[15:8];
            5'd11:   hdr_byte = csum_q[7:0];
            5'd12:   hdr_byte = src_q[31:24];
            5'd13:   hdr_byte = src_q[23:16];
            5'd14:   hdr_byte = src_q[15:8];
            5'd15:   hdr_byte = src_q[7:0];
            5'd16:   hdr_byte = dst_q[31:24];
            5'd17:   hdr_byte = dst_q[23:16];
            5'd18:   hdr_byte = dst_q[15:8];
            5'd19:   hdr_byte = dst_q[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = CSUM0;
            CSUM0:   state_d = CSUM1;
            CSUM1:   state_d = HEADER;
            HEADER:  if (hdr_cnt_q == 5'd19) state_d = (len_q == 16'd0) ? IDLE : PAYLOAD;
            PAYLOAD: if (last_acc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Configuration registers; a capture on the same edge sees the old value.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            target_ip_q <= P_ST_TARGET_IP;
            source_ip_q <= P_ST_SOURCE_IP;
        end else begin
            if (i_target_valid) target_ip_q <= i_target_ip;
            if (i_source_valid) source_ip_q <= i_source_ip;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            id_q        <= 16'd0;
            sel_icmp_q  <= 1'b0;
            len_q       <= 16'd0;
            pkt_id_q    <= 16'd0;
            proto_q     <= 8'd0;
            src_q       <= 32'd0;
            dst_q       <= 32'd0;
            sum_q       <= 32'd0;
            csum_q      <= 16'd0;
            hdr_cnt_q   <= 5'd0;
            pay_cnt_q   <= 16'd0;
            o_mac_data  <= 8'd0;
            o_mac_last  <= 1'b0;
            o_mac_valid <= 1'b0;
        end else begin
            o_mac_data  <= 8'd0;
            o_mac_last  <= 1'b0;
            o_mac_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    hdr_cnt_q <= 5'd0;
                    pay_cnt_q <= 16'd0;
                    if (any_req) begin
                        sel_icmp_q <= i_icmp_valid;
                        len_q      <= i_icmp_valid ? i_icmp_len : i_udp_len;
                        proto_q    <= i_icmp_valid ? 8'd1 : 8'd17;
                        src_q      <= source_ip_q;
                        dst_q      <= target_ip_q;
                        pkt_id_q   <= id_q;
                    end
                end
                CSUM0: sum_q <= sum_words;
                CSUM1: csum_q <= ~fold2;
                HEADER: begin
                    o_mac_valid <= 1'b1;
                    o_mac_data  <= hdr_byte;
                    hdr_cnt_q   <= hdr_cnt_q + 5'd1;
                    if (hdr_cnt_q == 5'd19 && len_q == 16'd0) begin
                        o_mac_last <= 1'b1;
                        id_q       <= id_q + 16'd1;
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        o_mac_valid <= 1'b1;
                        o_mac_data  <= in_data;
                        pay_cnt_q   <= pay_cnt_q + 16'd1;
                        if (last_acc) begin
                            o_mac_last <= 1'b1;
                            id_q       <= id_q + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ip_tx.sv
// Directed bench for ip_tx: a vector table of single packets plus hand-written
// sequences for arbitration, config updates, ID wrap and mid-packet reset.
module tb_ip_tx;

    localparam logic [31:0] SRC_DEF = 32'hC0A8_0101;
    localparam logic [31:0] DST_DEF = 32'hC0A8_0100;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_target_ip, i_source_ip;
    logic        i_target_valid, i_source_valid;
    logic [7:0]  i_udp_data, i_icmp_data;
    logic [15:0] i_udp_len, i_icmp_len;
    logic        i_udp_last, i_udp_valid, i_icmp_last, i_icmp_valid;
    logic        o_udp_ready, o_icmp_ready;
    logic [7:0]  o_mac_data;
    logic        o_mac_last, o_mac_valid;
    logic [2:0]  o_dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    ip_tx dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_target_ip(i_target_ip), .i_target_valid(i_target_valid),
        .i_source_ip(i_source_ip), .i_source_valid(i_source_valid),
        .i_udp_data(i_udp_data), .i_udp_len(i_udp_len), .i_udp_last(i_udp_last),
        .i_udp_valid(i_udp_valid), .o_udp_ready(o_udp_ready),
        .i_icmp_data(i_icmp_data), .i_icmp_len(i_icmp_len), .i_icmp_last(i_icmp_last),
        .i_icmp_valid(i_icmp_valid), .o_icmp_ready(o_icmp_ready),
        .o_mac_data(o_mac_data), .o_mac_last(o_mac_last), .o_mac_valid(o_mac_valid),
        .o_dbg_state(o_dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic        icmp;
        logic [15:0] len;
        logic [7:0]  base;
        int          gap_at;
        int          early_at;
        logic [15:0] exp_id;
        logic [15:0] exp_csum;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_csum(input logic [15:0] tl, input logic [15:0] id,
                                               input logic [7:0] proto, input logic [31:0] s,
                                               input logic [31:0] d);
        logic [31:0] sum;
        sum = 32'h4500 + tl + id + 32'h4000 + {16'b0, 8'd64, proto}
            + s[31:16] + s[15:0] + d[31:16] + d[15:0];
        sum = sum[15:0] + sum[31:16];
        sum = sum[15:0] + sum[31:16];
        return ~sum[15:0];
    endfunction

    // driver tasks
    task automatic set_ch(input logic icmp, input logic v, input logic [7:0] d,
                          input logic l, input logic [15:0] ln);
        if (icmp) begin
            i_icmp_valid = v; i_icmp_data = d; i_icmp_last = l; i_icmp_len = ln;
        end else begin
            i_udp_valid = v; i_udp_data = d; i_udp_last = l; i_udp_len = ln;
        end
    endtask

    task automatic drive(input string name, input logic icmp, input logic [15:0] len,
                         input logic [7:0] base, input int gap_at, input int early_at,
                         output int acc);
        int   k = 0;
        int   cyc = 0;
        int   gap_left;
        logic v, rdy;
        gap_left = (gap_at >= 0) ? 3 : 0;
        acc = 0;
        if (len == 16'd0) begin
            @(negedge clk);
            set_ch(icmp, 1'b1, 8'h00, 1'b1, 16'd0);
            @(negedge clk);
            set_ch(icmp, 1'b0, 8'h00, 1'b0, 16'd0);
            return;
        end
        while (k < int'(len) && cyc < 500) begin
            @(negedge clk);
            if (k == gap_at && gap_left > 0) begin
                set_ch(icmp, 1'b0, 8'h00, 1'b0, len);
                gap_left--;
                v = 1'b0;
            end else begin
                set_ch(icmp, 1'b1, base + 8'(k), (k == early_at), len);
                v = 1'b1;
            end
            #1 rdy = icmp ? o_icmp_ready : o_udp_ready;
            @(posedge clk);
            if (v && rdy) k++;
            cyc++;
        end
        acc = k;
        @(negedge clk);
        #1 rdy = icmp ? o_icmp_ready : o_udp_ready;
        check({name, " ready after len"}, rdy, 1'b0);
        set_ch(icmp, 1'b0, 8'h00, 1'b0, 16'd0);
    endtask

    // scoreboard: builds the expected byte queue and compares the MAC stream
    task automatic mon_pkt(input string name, input logic icmp, input logic [15:0] len,
                           input logic [7:0] base, input logic [15:0] id, input logic [31:0] src,
                           input logic [15:0] csum, input int exp_gap, input bit chk_start);
        logic [7:0]  exp_q[$];
        logic [15:0] tl;
        logic [7:0]  proto, exp_b;
        int wait_cyc = 0, gaps = 0, nbytes = 0, last_idx = -1, cyc = 0;
        int hdr_rdy_bad = 0, other_bad = 0;
        bit done = 0;
        logic rdy19 = 1'b0, sel_rdy, oth_rdy;
        tl    = len + 16'd20;
        proto = icmp ? 8'd1 : 8'd17;
        exp_q = '{8'h45, 8'h00, tl[15:8], tl[7:0], id[15:8], id[7:0], 8'h40, 8'h00,
                  8'd64, proto, csum[15:8], csum[7:0],
                  src[31:24], src[23:16], src[15:8], src[7:0],
                  DST_DEF[31:24], DST_DEF[23:16], DST_DEF[15:8], DST_DEF[7:0]};
        for (int i = 0; i < int'(len); i++) exp_q.push_back(base + 8'(i));
        do begin
            @(negedge clk);
            #1 wait_cyc++;
        end while (!o_mac_valid && wait_cyc < 200);
        if (chk_start) check({name, " start latency"}, wait_cyc, 5);
        if (!o_mac_valid) begin
            check({name, " packet start timeout"}, 0, 1);
            return;
        end
        while (!done && cyc < 2000) begin
            sel_rdy = icmp ? o_icmp_ready : o_udp_ready;
            oth_rdy = icmp ? o_udp_ready : o_icmp_ready;
            if (oth_rdy) other_bad++;
            if (o_mac_valid) begin
                if (nbytes < 19 && sel_rdy) hdr_rdy_bad++;
                if (nbytes == 19) rdy19 = sel_rdy;
                exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                check($sformatf("%s byte%0d", name, nbytes), o_mac_data, exp_b);
                if (o_mac_last) begin
                    done = 1;
                    last_idx = nbytes;
                end
                nbytes++;
            end else begin
                gaps++;
            end
            if (!done) begin
                @(negedge clk);
                #1 cyc++;
            end
        end
        check({name, " byte count"}, nbytes, 20 + int'(len));
        check({name, " last index"}, last_idx, 19 + int'(len));
        check({name, " valid gaps"}, gaps, exp_gap);
        check({name, " ready at byte19"}, rdy19, (len != 16'd0));
        check({name, " ready during header"}, hdr_rdy_bad, 0);
        check({name, " other ready"}, other_bad, 0);
    endtask

    task automatic run_pkt(input string name, input logic icmp, input logic [15:0] len,
                           input logic [7:0] base, input int gap_at, input int early_at,
                           input logic [15:0] id, input logic [31:0] src, input logic [15:0] csum);
        int acc;
        fork
            drive(name, icmp, len, base, gap_at, early_at, acc);
            mon_pkt(name, icmp, len, base, id, src, csum, (gap_at >= 0) ? 3 : 0, 1'b1);
        join
        check({name, " accepts"}, acc, int'(len));
    endtask

    initial begin
        int acc_a, acc_b, cyc;

        vecs[0] = '{1'b0, 16'd8,  8'h01, -1, -1, 16'h0000, 16'hB77F};
        vecs[1] = '{1'b0, 16'd0,  8'h00, -1, -1, 16'h0001, 16'hB786};
        vecs[2] = '{1'b1, 16'd5,  8'h20, -1, -1, 16'h0002, 16'hB790};
        vecs[3] = '{1'b0, 16'd12, 8'h30,  4,  5, 16'h0003, 16'hB778};
        vecs[4] = '{1'b1, 16'd1,  8'hF0, -1, -1, 16'h0004, 16'hB792};

        // clock / reset
        i_rst = 1'b1;
        i_target_ip = 32'd0; i_target_valid = 1'b0;
        i_source_ip = 32'd0; i_source_valid = 1'b0;
        set_ch(1'b0, 1'b0, 8'h00, 1'b0, 16'd0);
        set_ch(1'b1, 1'b0, 8'h00, 1'b0, 16'd0);
        repeat (3) @(negedge clk);
        check("reset mac_valid", o_mac_valid, 1'b0);
        check("reset mac_last", o_mac_last, 1'b0);
        check("reset mac_data", o_mac_data, 8'h00);
        check("reset udp_ready", o_udp_ready, 1'b0);
        check("reset icmp_ready", o_icmp_ready, 1'b0);
        check("reset state", o_dbg_state, 3'd0);
        i_rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_pkt($sformatf("vec%0d", i), vecs[i].icmp, vecs[i].len, vecs[i].base,
                    vecs[i].gap_at, vecs[i].early_at, vecs[i].exp_id, SRC_DEF, vecs[i].exp_csum);
        end

        // ICMP and UDP requesting on the same edge: ICMP wins, UDP follows
        fork
            drive("arb_icmp", 1'b1, 16'd3, 8'hA0, -1, -1, acc_a);
            drive("arb_udp", 1'b0, 16'd2, 8'hB0, -1, -1, acc_b);
            begin
                mon_pkt("arb_icmp", 1'b1, 16'd3, 8'hA0, 16'h0005, SRC_DEF,
                        model_csum(16'd23, 16'h0005, 8'd1, SRC_DEF, DST_DEF), 0, 1'b1);
                mon_pkt("arb_udp", 1'b0, 16'd2, 8'hB0, 16'h0006, SRC_DEF,
                        model_csum(16'd22, 16'h0006, 8'd17, SRC_DEF, DST_DEF), 0, 1'b0);
            end
        join
        check("arb_icmp accepts", acc_a, 3);
        check("arb_udp accepts", acc_b, 2);

        // source IP update while a packet is in flight
        fork
            drive("cfg_old", 1'b0, 16'd4, 8'h10, -1, -1, acc_a);
            mon_pkt("cfg_old", 1'b0, 16'd4, 8'h10, 16'h0007, SRC_DEF,
                    model_csum(16'd24, 16'h0007, 8'd17, SRC_DEF, DST_DEF), 0, 1'b1);
            begin
                repeat (10) @(negedge clk);
                i_source_ip = 32'h0A00_0005;
                i_source_valid = 1'b1;
                @(negedge clk);
                i_source_valid = 1'b0;
            end
        join
        check("cfg_old accepts", acc_a, 4);
        run_pkt("cfg_new", 1'b0, 16'd2, 8'h70, -1, -1, 16'h0008, 32'h0A00_0005,
                model_csum(16'd22, 16'h0008, 8'd17, 32'h0A00_0005, DST_DEF));

        // identification wrap
        @(negedge clk);
        force dut.id_q = 16'hFFFF;
        @(negedge clk);
        release dut.id_q;
        run_pkt("id_ffff", 1'b0, 16'd1, 8'h80, -1, -1, 16'hFFFF, 32'h0A00_0005,
                model_csum(16'd21, 16'hFFFF, 8'd17, 32'h0A00_0005, DST_DEF));
        run_pkt("id_wrap", 1'b0, 16'd0, 8'h00, -1, -1, 16'h0000, 32'h0A00_0005,
                model_csum(16'd20, 16'h0000, 8'd17, 32'h0A00_0005, DST_DEF));

        // asynchronous reset while payload byte 3 is on the output
        acc_a = 0;
        cyc = 0;
        @(negedge clk);
        set_ch(1'b0, 1'b1, 8'h55, 1'b0, 16'd10);
        while (acc_a < 3 && cyc < 100) begin
            #1 if (o_udp_ready) acc_a++;
            @(posedge clk);
            cyc++;
            if (acc_a < 3) @(negedge clk);
        end
        check("rst accepts before reset", acc_a, 3);
        #2 check("rst mac_valid before reset", o_mac_valid, 1'b1);
        i_rst = 1'b1;
        #1;
        check("rst async mac_valid", o_mac_valid, 1'b0);
        check("rst async mac_data", o_mac_data, 8'h00);
        check("rst async mac_last", o_mac_last, 1'b0);
        check("rst async udp_ready", o_udp_ready, 1'b0);
        check("rst async state", o_dbg_state, 3'd0);
        @(negedge clk);
        set_ch(1'b0, 1'b0, 8'h00, 1'b0, 16'd0);
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        run_pkt("post_rst", 1'b0, 16'd2, 8'h60, -1, -1, 16'h0000, SRC_DEF,
                model_csum(16'd22, 16'h0000, 8'd17, SRC_DEF, DST_DEF));

        // final report
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
